mem_req_arbiter: RTL
====================

// Module: mem_req_arbiter
// PURPOSE
//  Parametrised N-requester arbiter funnelling miss-repair/write-back requests from upper cache
//  levels (L1-I, L1-D, victim cache) into one lower-level port (L2 or AXI RAM controller).
//  Round-robin grant, registered downstream request, up to MAX_OUT in-order outstanding
//  transactions. An ID FIFO routes each downstream response back to its requester.
// PARAMETERS
//  NUM_REQ  2   number of requesters (>=2)
//  ADDR_W   32  address width
//  DATA_W   128 line/data width (one cache block per transaction)
//  MAX_OUT  4   max transactions issued and not yet answered (>=1)
// PORTS
//  clk             in   1               clock, all logic rising-edge
//  rst             in   1               synchronous, active-high reset
//  req_valid       in   NUM_REQ         per-requester request valid
//  req_ready       out  NUM_REQ         per-requester accept
//  req_we          in   NUM_REQ         1=write (write-back), 0=read (fill)
//  req_addr        in   NUM_REQ*ADDR_W  packed, requester i at [i*ADDR_W +: ADDR_W]
//  req_wdata       in   NUM_REQ*DATA_W  packed write data
//  resp_valid      out  NUM_REQ         one-cycle response strobe to requester i
//  resp_rdata      out  DATA_W          response data, broadcast, qualified by resp_valid
//  mem_req_valid   out  1               downstream request valid
//  mem_req_ready   in   1               downstream accept
//  mem_req_we      out  1               downstream write flag
//  mem_req_addr    out  ADDR_W          downstream address
//  mem_req_wdata   out  DATA_W          downstream write data
//  mem_resp_valid  in   1               downstream response (reads and write acks, in order)
//  mem_resp_rdata  in   DATA_W          downstream response data
//  err_resp        out  1               sticky: response received with no transaction outstanding
// BEHAVIOUR
//  Reset: req_ready=0, resp_valid=0, resp_rdata=0, mem_req_valid/we/addr/wdata=0, err_resp=0,
//   RR pointer=0, ID FIFO empty, outstanding count=0. Reset mid-operation drops all in-flight
//   state without emitting responses; the downstream side is reset on the same rst.
//  Outstanding count cnt ($clog2(MAX_OUT+1) bits) = transactions accepted from requesters
//   and not yet answered (includes one held in the output register).
//  can_issue = (!mem_req_valid || mem_req_ready) && (cnt < MAX_OUT); uses registered cnt, so a
//   response popping in the same cycle does not free a slot until the next cycle.
//  Arbitration (combinational): search req_valid starting at RR pointer, wrapping at NUM_REQ-1
//   -> 0; first set bit wins. req_ready[i] = can_issue && grant[i]; at most one bit set.
//   req_ready must not depend on req_valid of the same requester (no valid->ready loop beyond grant).
//  Accept (req_valid[i] && req_ready[i]): next cycle mem_req_valid=1 with requester i's we/addr/
//   wdata; ID i pushed to FIFO; cnt+1; RR pointer = (i+1) mod NUM_REQ. Latency accept -> mem_req_valid: 1 cycle.
//  No accept: RR pointer unchanged. mem_req_valid && !mem_req_ready: all mem_req_* held stable.
//  mem_req_ready with no new accept: mem_req_valid drops to 0 next cycle.
//  Response: mem_resp_valid && FIFO non-empty -> same cycle (combinational) resp_valid[head]=1,
//   resp_rdata=mem_resp_rdata; FIFO pop; cnt-1. Accept and response in same cycle: cnt unchanged.
//  mem_resp_valid with FIFO empty: no resp_valid, no pop, err_resp set until rst.
//  FIFO: depth MAX_OUT, pointers wrap modulo MAX_OUT; cnt < MAX_OUT guarantees no overflow.
//  Ordering: downstream responds strictly in request order; no same-address merging or forwarding.
// TESTING
//  1 Single read: rst then req_valid[1]=1 addr=0x1000 -> req_ready[1]=1 cycle0, mem_req_valid=1
//    addr=0x1000 we=0 cycle1; mem_resp_valid rdata=0xAB -> resp_valid=2'b10, resp_rdata=0xAB.
//  2 Fairness: NUM_REQ=2, both valid continuously, mem_req_ready=1, responses immediate ->
//    grants alternate 0,1,0,1 over 8 accepts (4 each).
//  3 Backpressure: mem_req_ready=0 for 5 cycles -> mem_req_* stable, req_ready all 0, no RR change;
//    ready=1 -> transfer, next request issued following cycle.
//  4 Outstanding limit: MAX_OUT=4, no responses, 6 requests offered -> exactly 4 accepted, cnt=4,
//    req_ready=0; one response -> fifth accepted the cycle after the response, not same cycle.
//  5 Routing: accepts in order R0(wr),R1(rd),R0(rd); 3 responses -> resp_valid 01,10,01 in order.
//  6 Errors/reset: mem_resp_valid with nothing outstanding -> err_resp=1, no resp_valid; rst with
//    3 outstanding -> next cycle cnt=0, mem_req_valid=0, err_resp=0, later responses set err_resp.

Source files
------------

// File: rtl/mem_req_arbiter.sv
// Round-robin N-to-1 arbiter for cache miss/write-back traffic with a registered downstream
// request and an in-order ID FIFO that steers each downstream response back to its requester.
module mem_req_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 128,
   parameter int MAX_OUT = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [NUM_REQ-1:0]        req_we,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
   output logic [NUM_REQ-1:0]        resp_valid,
   output logic [DATA_W-1:0]         resp_rdata,
   output logic                      mem_req_valid,
   input  logic                      mem_req_ready,
   output logic                      mem_req_we,
   output logic [ADDR_W-1:0]         mem_req_addr,
   output logic [DATA_W-1:0]         mem_req_wdata,
   input  logic                      mem_resp_valid,
   input  logic [DATA_W-1:0]         mem_resp_rdata,
   output logic                      err_resp
);

   localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CW = $clog2(MAX_OUT + 1);
   localparam int FW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
   localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUT);

   logic [PW-1:0]      rr_ptr;
   logic [PW-1:0]      win_id;
   logic [PW-1:0]      head_id;
   logic [CW-1:0]      cnt;
   logic [FW-1:0]      wr_ptr;
   logic [FW-1:0]      rd_ptr;
   logic [PW-1:0]      id_mem [MAX_OUT];
   logic [NUM_REQ-1:0] grant;
   logic [PW:0]        arb_sum;
   logic               found;
   logic               can_issue;
   logic               accept;
   logic               pop;
   logic               sel_we;
   logic [ADDR_W-1:0]  sel_addr;
   logic [DATA_W-1:0]  sel_wdata;

   function automatic logic [PW-1:0] rr_next(input logic [PW-1:0] id);
      return (id == PW'(NUM_REQ - 1)) ? '0 : id + 1'b1;
   endfunction

   function automatic logic [FW-1:0] fifo_next(input logic [FW-1:0] p);
      return (p == FW'(MAX_OUT - 1)) ? '0 : p + 1'b1;
   endfunction

   // A slot freed by a response this cycle only becomes usable next cycle (registered cnt).
   assign can_issue = !rst && (!mem_req_valid || mem_req_ready) && (cnt < MAX_CNT);

   always_comb begin
      found   = 1'b0;
      win_id  = '0;
      arb_sum = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         arb_sum = {1'b0, rr_ptr} + (PW+1)'(k);
         if (arb_sum >= (PW+1)'(NUM_REQ))
            arb_sum = arb_sum - (PW+1)'(NUM_REQ);
         if (!found && req_valid[arb_sum[PW-1:0]]) begin
            found  = 1'b1;
            win_id = arb_sum[PW-1:0];
         end
      end
      grant = found ? (NUM_REQ'(1) << win_id) : '0;
   end

   assign req_ready = can_issue ? grant : '0;
   assign accept    = can_issue && found;

   always_comb begin
      sel_we    = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            sel_we    = req_we[i];
            sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
            sel_wdata = req_wdata[i*DATA_W +: DATA_W];
         end
      end
   end

   // The FIFO holds exactly cnt IDs, so cnt doubles as the occupancy.
   assign head_id    = id_mem[rd_ptr];
   assign pop        = !rst && mem_resp_valid && (cnt != '0);
   assign resp_valid = pop ? (NUM_REQ'(1) << head_id) : '0;
   assign resp_rdata = pop ? mem_resp_rdata : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_req_valid <= 1'b0;
         mem_req_we    <= 1'b0;
         mem_req_addr  <= '0;
         mem_req_wdata <= '0;
         rr_ptr        <= '0;
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         cnt           <= '0;
         err_resp      <= 1'b0;
      end else begin
         if (accept) begin
            mem_req_valid <= 1'b1;
            mem_req_we    <= sel_we;
            mem_req_addr  <= sel_addr;
            mem_req_wdata <= sel_wdata;
            wr_ptr        <= fifo_next(wr_ptr);
            rr_ptr        <= rr_next(win_id);
         end else if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
         end
         if (pop)
            rd_ptr <= fifo_next(rd_ptr);
         if (mem_resp_valid && (cnt == '0))
            err_resp <= 1'b1;
         if (accept && !pop)
            cnt <= cnt + 1'b1;
         else if (!accept && pop)
            cnt <= cnt - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (accept)
         id_mem[wr_ptr] <= win_id;
   end

endmodule
